// File: rtl/arb_rr_lock.sv
// arb_rr_lock: round-robin arbiter with per-requester burst lock.
//
// One downstream resource is shared among N requesters. The grant outputs
// (gnt, gnt_vld, gnt_idx, tmo) are all registered, so no input reaches an
// output combinationally. A holder keeps the grant while both its req and
// its lock bits stay high. When it releases, a new winner is picked in the
// same cycle, so a handover never leaves an idle cycle.
//
// Optional feature: define ARB_RR_LOCK_TIMEOUT_EN to bound a locked hold to
// MAX_HOLD consecutive cycles. The forced release pulses tmo. When the macro
// is undefined, holds have no limit, tmo stays 0 and MAX_HOLD is ignored.
//
// Grant handshake: gnt_vld=1 means the requester named by gnt/gnt_idx owns
// the resource for this cycle. There is no ready. A requester keeps the
// grant past this cycle only by holding req and lock high. gnt_vld=0 means
// gnt=0 and gnt_idx=0.

module arb_rr_lock #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         lock,
    output logic [N-1:0]         gnt,
    output logic                 gnt_vld,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 tmo,
    output logic                 state_dbg,
    output logic [$clog2(N)-1:0] ptr_dbg
);

    localparam int IW = $clog2(N);
    localparam int SW = IW + 1;
    localparam logic [SW-1:0] N_W        = SW'(N);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
    localparam logic [15:0]   MAX_HOLD_W = 16'(MAX_HOLD);
    localparam logic [15:0]   HC_SAT     = 16'hFFFF;

`ifdef ARB_RR_LOCK_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [15:0]   hc, hc_n;

    logic [N-1:0]  gnt_n;
    logic [IW-1:0] idx_n;
    logic          vld_n;
    logic          tmo_n;

    logic          win_vld;
    logic [IW-1:0] win_idx;
    logic [SW-1:0] scan;

    logic          keep;
    logic          hold_expired;
    logic          force_rel;

    // A locked holder stays only while its own req and lock are both high.
    // Lock bits from any other requester have no effect.
    assign keep         = (state == BUSY) && req[gnt_idx] && lock[gnt_idx];
    assign hold_expired = (hc >= MAX_HOLD_W);
    assign force_rel    = TMO_EN && keep && hold_expired;

    // Rotating priority scan. It starts at ptr and wraps modulo N. The last
    // winner sits at ptr-1, so it comes last in the scan.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        scan    = '0;
        for (int i = 0; i < N; i++) begin
            scan = {1'b0, ptr} + SW'(i);
            if (scan >= N_W) begin
                scan = scan - N_W;
            end
            if (!win_vld && req[scan[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = scan[IW-1:0];
            end
        end
    end

    // Next-state logic: grant, keep, hand over, or go idle.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hc_n    = hc;
        gnt_n   = gnt;
        idx_n   = gnt_idx;
        vld_n   = gnt_vld;
        tmo_n   = 1'b0;

        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_n = BUSY;
                    gnt_n   = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    idx_n   = win_idx;
                    vld_n   = 1'b1;
                    hc_n    = 16'd1;
                    ptr_n   = (win_idx == LAST_IDX) ? '0 : win_idx + IW'(1);
                end else begin
                    gnt_n   = '0;
                    idx_n   = '0;
                    vld_n   = 1'b0;
                end
            end
            BUSY: begin
                if (keep && !force_rel) begin
                    hc_n = (hc == HC_SAT) ? hc : hc + 16'd1;
                end else if (win_vld) begin
                    // A release or forced release hands the grant over with no gap.
                    gnt_n   = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    idx_n   = win_idx;
                    vld_n   = 1'b1;
                    hc_n    = 16'd1;
                    tmo_n   = force_rel;
                    ptr_n   = (win_idx == LAST_IDX) ? '0 : win_idx + IW'(1);
                end else begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    idx_n   = '0;
                    vld_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                idx_n   = '0;
                vld_n   = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            hc      <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            tmo     <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            hc      <= hc_n;
            gnt     <= gnt_n;
            gnt_idx <= idx_n;
            gnt_vld <= vld_n;
            tmo     <= tmo_n;
        end
    end

    assign state_dbg = (state == BUSY);
    assign ptr_dbg   = ptr;

endmodule
